// File: rtl/counter_xn.sv
// counter_xn: CH prescaled down-counters with stop/one-shot/periodic/square modes.
// Register port on the MIO bus, per-channel outputs and a maskable irq.
module counter_xn #(
  parameter int CH      = 3,
  parameter int CHW     = 2,
  parameter int WIDTH   = 32,
  parameter int PRESC_W = 8
) (
  input  logic             clk,
  input  logic             RSTN,
  input  logic             counter_we,
  input  logic [CHW-1:0]   counter_ch,
  input  logic [1:0]       reg_sel,
  input  logic [WIDTH-1:0] counter_val,
  output logic [WIDTH-1:0] counter_out,
  output logic [CH-1:0]    counter_OUT,
  output logic             irq
);

  typedef enum logic [1:0] {
    M_STOP = 2'b00,
    M_ONE  = 2'b01,
    M_PER  = 2'b10,
    M_SQR  = 2'b11
  } mode_e;

  logic [WIDTH-1:0]   cnt_q    [CH];
  logic [WIDTH-1:0]   cnt_d    [CH];
  logic [WIDTH-1:0]   reload_q [CH];
  logic [WIDTH-1:0]   reload_d [CH];
  logic [PRESC_W-1:0] presc_q  [CH];
  logic [PRESC_W-1:0] presc_d  [CH];
  logic [PRESC_W-1:0] pc_q     [CH];
  logic [PRESC_W-1:0] pc_d     [CH];
  mode_e              mode_q   [CH];
  mode_e              mode_d   [CH];

  logic [CH-1:0] irqen_q, irqen_d;
  logic [CH-1:0] run_q, run_d;
  logic [CH-1:0] out_q, out_d;
  logic [CH-1:0] sts_q, sts_d;
  logic [CH-1:0] ev;
  logic [CH-1:0] clr;

  logic sel;
  logic ld;
  logic cw;
  logic act;
  logic tick;

  // Next state per channel: a LOAD/CTRL write to a channel beats its tick.
  always_comb begin
    ev   = '0;
    sel  = 1'b0;
    ld   = 1'b0;
    cw   = 1'b0;
    act  = 1'b0;
    tick = 1'b0;
    irqen_d = irqen_q;
    run_d   = run_q;
    out_d   = out_q;
    for (int i = 0; i < CH; i++) begin
      cnt_d[i]    = cnt_q[i];
      reload_d[i] = reload_q[i];
      presc_d[i]  = presc_q[i];
      pc_d[i]     = pc_q[i];
      mode_d[i]   = mode_q[i];
      sel  = counter_we && (counter_ch == CHW'(i));
      ld   = sel && (reg_sel == 2'd0);
      cw   = sel && (reg_sel == 2'd1);
      act  = (mode_q[i] != M_STOP) && run_q[i];
      tick = act && (pc_q[i] == presc_q[i]);
      unique case (1'b1)
        ld: begin
          cnt_d[i]    = counter_val;
          reload_d[i] = counter_val;
          pc_d[i]     = '0;
          out_d[i]    = 1'b0;
          run_d[i]    = (counter_val != '0);
        end
        cw: begin
          mode_d[i]   = mode_e'(counter_val[1:0]);
          irqen_d[i]  = counter_val[2];
          presc_d[i]  = counter_val[PRESC_W+7:8];
          pc_d[i]     = '0;
          out_d[i]    = 1'b0;
        end
        default: begin
          if (act) begin
            pc_d[i] = tick ? '0 : pc_q[i] + 1'b1;
          end
          if (mode_q[i] == M_PER) begin
            out_d[i] = 1'b0;
          end
          if (tick && (cnt_q[i] > WIDTH'(1))) begin
            cnt_d[i] = cnt_q[i] - 1'b1;
          end else if (tick && (cnt_q[i] == WIDTH'(1))) begin
            ev[i] = 1'b1;
            unique case (mode_q[i])
              M_ONE: begin
                cnt_d[i] = '0;
                run_d[i] = 1'b0;
                out_d[i] = 1'b1;
              end
              M_PER: begin
                cnt_d[i] = reload_q[i];
                out_d[i] = 1'b1;
              end
              default: begin
                cnt_d[i] = reload_q[i];
                out_d[i] = ~out_q[i];
              end
            endcase
          end
        end
      endcase
    end
  end

  // Status is sticky; a new event wins over a same-cycle clear.
  always_comb begin
    clr = '0;
    if (counter_we && (reg_sel == 2'd2)) begin
      clr = counter_val[CH-1:0];
    end
    sts_d = (sts_q & ~clr) | ev;
  end

  // Channel state registers.
  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      for (int i = 0; i < CH; i++) begin
        cnt_q[i]    <= '0;
        reload_q[i] <= '0;
        presc_q[i]  <= '0;
        pc_q[i]     <= '0;
        mode_q[i]   <= M_STOP;
      end
      irqen_q <= '0;
      run_q   <= '0;
      out_q   <= '0;
      sts_q   <= '0;
    end else begin
      for (int i = 0; i < CH; i++) begin
        cnt_q[i]    <= cnt_d[i];
        reload_q[i] <= reload_d[i];
        presc_q[i]  <= presc_d[i];
        pc_q[i]     <= pc_d[i];
        mode_q[i]   <= mode_d[i];
      end
      irqen_q <= irqen_d;
      run_q   <= run_d;
      out_q   <= out_d;
      sts_q   <= sts_d;
    end
  end

  logic [WIDTH-1:0] rd_cnt;
  logic [WIDTH-1:0] rd_rel;
  logic [WIDTH-1:0] rd_ctl;
  logic [WIDTH-1:0] rd_sts;

  // Read mux; an unmatched channel leaves everything but status at 0.
  always_comb begin
    rd_cnt = '0;
    rd_rel = '0;
    rd_ctl = '0;
    rd_sts = '0;
    rd_sts[CH-1:0] = sts_q;
    for (int i = 0; i < CH; i++) begin
      if (counter_ch == CHW'(i)) begin
        rd_cnt = cnt_q[i];
        rd_rel = reload_q[i];
        rd_ctl[1:0] = mode_q[i];
        rd_ctl[2]   = irqen_q[i];
        rd_ctl[PRESC_W+7:8] = presc_q[i];
      end
    end
    unique case (reg_sel)
      2'd0:    counter_out = rd_cnt;
      2'd1:    counter_out = rd_ctl;
      2'd2:    counter_out = rd_sts;
      default: counter_out = rd_rel;
    endcase
  end

  assign counter_OUT = out_q;
  assign irq         = |(sts_q & irqen_q);

endmodule

// File: tb/tb_counter_xn.sv
// tb_counter_xn: directed bench for counter_xn.
// One task per scenario, expected values computed by hand.
module tb_counter_xn;

  logic        clk = 1'b0;
  logic        RSTN;
  logic        counter_we;
  logic [1:0]  counter_ch;
  logic [1:0]  reg_sel;
  logic [31:0] counter_val;
  logic [31:0] counter_out;
  logic [2:0]  counter_OUT;
  logic        irq;

  int n_chk  = 0;
  int n_fail = 0;
  logic [31:0] r;

  counter_xn #(
    .CH(3), .CHW(2), .WIDTH(32), .PRESC_W(8)
  ) dut (
    .clk(clk),
    .RSTN(RSTN),
    .counter_we(counter_we),
    .counter_ch(counter_ch),
    .reg_sel(reg_sel),
    .counter_val(counter_val),
    .counter_out(counter_out),
    .counter_OUT(counter_OUT),
    .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic tick1();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] ch, input logic [1:0] s,
                    input logic [31:0] v);
    counter_ch  = ch;
    reg_sel     = s;
    counter_val = v;
    counter_we  = 1'b1;
    @(posedge clk);
    #1;
    counter_we  = 1'b0;
  endtask

  task automatic rd(input logic [1:0] ch, input logic [1:0] s,
                    output logic [31:0] v);
    counter_ch = ch;
    reg_sel    = s;
    #1;
    v = counter_out;
  endtask

  task automatic test_reset();
    RSTN = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    RSTN = 1'b1;
    tick1();
    for (int c = 0; c < 4; c++) begin
      for (int s = 0; s < 4; s++) begin
        rd(2'(c), 2'(s), r);
        n_chk++;
        if (r !== 32'd0) begin
          n_fail++;
          $display("FAIL rst_rd ch%0d sel%0d: got %h want 0", c, s, r);
        end
      end
      tick1();
    end
    n_chk++;
    if (counter_OUT !== 3'b000) begin
      n_fail++;
      $display("FAIL rst_out: got %b want 000", counter_OUT);
    end
    n_chk++;
    if (irq !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_irq: got %b want 0", irq);
    end
  endtask

  task automatic test_oneshot();
    wr(0, 1, 32'h1);
    wr(0, 0, 32'd5);
    rd(0, 0, r);
    n_chk++;
    if (r !== 32'd5) begin
      n_fail++;
      $display("FAIL os_load: got %0d want 5", r);
    end
    for (int k = 1; k <= 4; k++) begin
      tick1();
      rd(0, 0, r);
      n_chk++;
      if (r !== 32'(5 - k)) begin
        n_fail++;
        $display("FAIL os_cnt k%0d: got %0d want %0d", k, r, 5 - k);
      end
      n_chk++;
      if (counter_OUT[0] !== 1'b0) begin
        n_fail++;
        $display("FAIL os_out_early k%0d: got %b want 0", k, counter_OUT[0]);
      end
    end
    tick1();
    rd(0, 0, r);
    n_chk++;
    if (r !== 32'd0) begin
      n_fail++;
      $display("FAIL os_end_cnt: got %0d want 0", r);
    end
    n_chk++;
    if (counter_OUT !== 3'b001) begin
      n_fail++;
      $display("FAIL os_end_out: got %b want 001", counter_OUT);
    end
    rd(0, 2, r);
    n_chk++;
    if (r !== 32'h1) begin
      n_fail++;
      $display("FAIL os_sts: got %h want 1", r);
    end
    n_chk++;
    if (irq !== 1'b0) begin
      n_fail++;
      $display("FAIL os_irq_masked: got %b want 0", irq);
    end
    tick1();
    tick1();
    rd(0, 0, r);
    n_chk++;
    if (r !== 32'd0 || counter_OUT[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL os_hold: got cnt %0d out %b want 0/1", r, counter_OUT[0]);
    end
    wr(0, 1, 32'h5);
    n_chk++;
    if (irq !== 1'b1) begin
      n_fail++;
      $display("FAIL os_irq_en: got %b want 1", irq);
    end
    n_chk++;
    if (counter_OUT[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL os_ctrl_clr: got %b want 0", counter_OUT[0]);
    end
    wr(0, 2, 32'h1);
    n_chk++;
    if (irq !== 1'b0) begin
      n_fail++;
      $display("FAIL os_w1c_irq: got %b want 0", irq);
    end
    rd(0, 2, r);
    n_chk++;
    if (r !== 32'h0) begin
      n_fail++;
      $display("FAIL os_w1c_sts: got %h want 0", r);
    end
  endtask

  task automatic test_periodic();
    logic e;
    wr(1, 1, 32'h302);
    wr(1, 0, 32'd2);
    for (int k = 1; k <= 24; k++) begin
      tick1();
      e = ((k % 8) == 0);
      n_chk++;
      if (counter_OUT[1] !== e) begin
        n_fail++;
        $display("FAIL per_out k%0d: got %b want %b", k, counter_OUT[1], e);
      end
    end
    wr(1, 1, 32'h0);
    rd(1, 2, r);
    n_chk++;
    if (r !== 32'h2) begin
      n_fail++;
      $display("FAIL per_sts: got %h want 2", r);
    end
  endtask

  task automatic test_square();
    logic e;
    wr(2, 1, 32'h3);
    wr(2, 0, 32'd3);
    for (int k = 1; k <= 13; k++) begin
      tick1();
      e = (((k / 3) % 2) == 1);
      n_chk++;
      if (counter_OUT[2] !== e) begin
        n_fail++;
        $display("FAIL sq_out k%0d: got %b want %b", k, counter_OUT[2], e);
      end
    end
    wr(2, 1, 32'h0);
    rd(2, 0, r);
    n_chk++;
    if (r !== 32'd2 || counter_OUT[2] !== 1'b0) begin
      n_fail++;
      $display("FAIL sq_stop: got cnt %0d out %b want 2/0", r, counter_OUT[2]);
    end
    repeat (3) tick1();
    rd(2, 0, r);
    n_chk++;
    if (r !== 32'd2) begin
      n_fail++;
      $display("FAIL sq_frozen: got %0d want 2", r);
    end
    wr(2, 1, 32'h3);
    tick1();
    rd(2, 0, r);
    n_chk++;
    if (r !== 32'd1) begin
      n_fail++;
      $display("FAIL sq_resume: got %0d want 1", r);
    end
    tick1();
    rd(2, 0, r);
    n_chk++;
    if (r !== 32'd3 || counter_OUT[2] !== 1'b1) begin
      n_fail++;
      $display("FAIL sq_resume_ev: got cnt %0d out %b want 3/1", r, counter_OUT[2]);
    end
    wr(2, 1, 32'h0);
    wr(0, 2, 32'h4);
    rd(2, 2, r);
    n_chk++;
    if (r !== 32'h2) begin
      n_fail++;
      $display("FAIL sq_w1c: got %h want 2", r);
    end
  endtask

  task automatic test_back_to_back();
    wr(0, 1, 32'h2);
    wr(0, 0, 32'd1);
    wr(0, 2, 32'h1);
    rd(0, 2, r);
    n_chk++;
    if (r !== 32'h3) begin
      n_fail++;
      $display("FAIL b2b_set_wins: got %h want 3", r);
    end
    n_chk++;
    if (counter_OUT[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_pulse: got %b want 1", counter_OUT[0]);
    end
    wr(0, 1, 32'h0);
    rd(0, 0, r);
    n_chk++;
    if (r !== 32'd1 || counter_OUT[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_stop: got cnt %0d out %b want 1/0", r, counter_OUT[0]);
    end
    wr(0, 2, 32'h1);
    wr(0, 1, 32'h2);
    wr(0, 0, 32'd7);
    rd(0, 2, r);
    n_chk++;
    if (r !== 32'h2) begin
      n_fail++;
      $display("FAIL b2b_load_wins_sts: got %h want 2", r);
    end
    rd(0, 0, r);
    n_chk++;
    if (r !== 32'd7 || counter_OUT[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_load_wins_cnt: got cnt %0d out %b want 7/0", r, counter_OUT[0]);
    end
    wr(0, 1, 32'h0);
    rd(0, 0, r);
    n_chk++;
    if (r !== 32'd7) begin
      n_fail++;
      $display("FAIL b2b_ctrl_wins: got %0d want 7", r);
    end
  endtask

  task automatic test_out_of_range();
    wr(3, 0, 32'h55);
    wr(3, 1, 32'h3);
    for (int s = 0; s < 4; s++) begin
      rd(3, 2'(s), r);
      n_chk++;
      if (r !== ((s == 2) ? 32'h2 : 32'h0)) begin
        n_fail++;
        $display("FAIL oob_rd sel%0d: got %h want %h", s, r,
                 ((s == 2) ? 32'h2 : 32'h0));
      end
    end
    tick1();
    rd(0, 3, r);
    n_chk++;
    if (r !== 32'd7) begin
      n_fail++;
      $display("FAIL oob_ch0_rel: got %0d want 7", r);
    end
    rd(1, 3, r);
    n_chk++;
    if (r !== 32'd2) begin
      n_fail++;
      $display("FAIL oob_ch1_rel: got %0d want 2", r);
    end
    rd(2, 3, r);
    n_chk++;
    if (r !== 32'd3) begin
      n_fail++;
      $display("FAIL oob_ch2_rel: got %0d want 3", r);
    end
    rd(2, 1, r);
    n_chk++;
    if (r !== 32'h0) begin
      n_fail++;
      $display("FAIL oob_ch2_ctl: got %h want 0", r);
    end
  endtask

  task automatic test_load_zero();
    wr(0, 1, 32'h2);
    wr(0, 0, 32'd0);
    repeat (100) tick1();
    rd(0, 0, r);
    n_chk++;
    if (r !== 32'd0) begin
      n_fail++;
      $display("FAIL lz_cnt: got %0d want 0", r);
    end
    rd(0, 1, r);
    n_chk++;
    if (r !== 32'h2) begin
      n_fail++;
      $display("FAIL lz_ctl: got %h want 2", r);
    end
    rd(0, 2, r);
    n_chk++;
    if (r !== 32'h2 || counter_OUT !== 3'b000) begin
      n_fail++;
      $display("FAIL lz_no_event: got sts %h out %b want 2/000", r, counter_OUT);
    end
  endtask

  task automatic test_reset_mid();
    wr(2, 1, 32'h7);
    wr(2, 0, 32'd2);
    tick1();
    tick1();
    n_chk++;
    if (irq !== 1'b1 || counter_OUT[2] !== 1'b1) begin
      n_fail++;
      $display("FAIL rm_pre: got irq %b out %b want 1/1", irq, counter_OUT[2]);
    end
    #2;
    RSTN = 1'b0;
    #1;
    n_chk++;
    if (irq !== 1'b0 || counter_OUT !== 3'b000) begin
      n_fail++;
      $display("FAIL rm_async: got irq %b out %b want 0/000", irq, counter_OUT);
    end
    rd(1, 2, r);
    n_chk++;
    if (r !== 32'h0) begin
      n_fail++;
      $display("FAIL rm_sts: got %h want 0", r);
    end
    tick1();
    RSTN = 1'b1;
    repeat (5) tick1();
    rd(2, 0, r);
    n_chk++;
    if (r !== 32'd0 || counter_OUT !== 3'b000) begin
      n_fail++;
      $display("FAIL rm_idle: got cnt %0d out %b want 0/000", r, counter_OUT);
    end
    rd(2, 1, r);
    n_chk++;
    if (r !== 32'h0) begin
      n_fail++;
      $display("FAIL rm_ctl: got %h want 0", r);
    end
  endtask

  initial begin
    RSTN        = 1'b0;
    counter_we  = 1'b0;
    counter_ch  = '0;
    reg_sel     = '0;
    counter_val = '0;
    test_reset();
    test_oneshot();
    test_periodic();
    test_square();
    test_back_to_back();
    test_out_of_range();
    test_load_zero();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
